// File: rtl/potential_decay_scheduler_pkg.sv
// Shared definitions for the potential-decay scheduler: FSM states, decay-rate codes,
// the IEEE-754 magnitude mask and the rate legalisation helper.
package potential_decay_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_READ    = 3'd1,
        ST_WAIT_RD = 3'd2,
        ST_ISSUE   = 3'd3,
        ST_WRITE   = 3'd4,
        ST_NEXT    = 3'd5,
        ST_DONE    = 3'd6
    } state_e;

    localparam logic [3:0] RATE_DIV1   = 4'b0001;
    localparam logic [3:0] RATE_DIV2   = 4'b0010;
    localparam logic [3:0] RATE_DIV4   = 4'b0100;
    localparam logic [3:0] RATE_DIV8   = 4'b1000;
    localparam logic [3:0] RATE_DIV2P4 = 4'b0011;

    localparam logic [30:0] FP_MAG_MASK = 31'h7FFFFFFF;

    // Unknown rate codes fall back to pass-through so the decay unit never sees garbage.
    function automatic logic [3:0] legal_rate(input logic [3:0] cfg);
        case (cfg)
            RATE_DIV1, RATE_DIV2, RATE_DIV4, RATE_DIV8, RATE_DIV2P4: legal_rate = cfg;
            default:                                                 legal_rate = RATE_DIV1;
        endcase
    endfunction

endpackage

// File: rtl/potential_decay_scheduler_neuron_index_counter.sv
// Neuron index register for the decay sweep: synchronous clear, increment that
// saturates at NUM_NEURONS-1, and a terminal-count flag.
module neuron_index_counter #(
    parameter int NUM_NEURONS = 30,
    parameter int ADDR_W      = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr_i,
    input  logic              inc_i,
    output logic [ADDR_W-1:0] idx_o,
    output logic              last_o
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_NEURONS - 1);

    logic [ADDR_W-1:0] idx_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            idx_q <= '0;
        end else if (clr_i) begin
            idx_q <= '0;
        end else if (inc_i && (idx_q != LAST_IDX)) begin
            idx_q <= idx_q + 1'b1;
        end
    end

    assign idx_o  = idx_q;
    assign last_o = (idx_q == LAST_IDX);

endmodule

// File: rtl/potential_decay_scheduler.sv
// Time-shared LIF potential-decay sequencer: read, decay via req/ack, write back for each neuron.
// Optional build macro DECAY_SCHED_SKIP_ZERO_EN skips neurons whose potential is +0/-0.
module potential_decay_scheduler
    import potential_decay_scheduler_pkg::*;
#(
    parameter int NUM_NEURONS = 30,
    parameter int ADDR_W      = 5
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              timestep_start,
    input  logic              cfg_we,
    input  logic [3:0]        decay_rate_cfg,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_rd_data,
    output logic              mem_wr_en,
    output logic [31:0]       mem_wr_data,
    output logic              dec_req,
    output logic [31:0]       dec_operand,
    output logic [3:0]        dec_rate,
    input  logic              dec_ack,
    input  logic [31:0]       dec_result,
    output logic              busy,
    output logic              done,
    output logic              overrun
);

    state_e      state_q;
    logic [31:0] operand_q;
    logic [31:0] result_q;
    logic [3:0]  rate_q;
    logic        rd_en_q;
    logic        wr_en_q;
    logic        req_q;
    logic        busy_q;
    logic        done_q;

    logic              idx_last;
    logic [ADDR_W-1:0] idx;
    logic              start_ok;

    // A new sweep may start from IDLE or straight out of DONE.
    assign start_ok = timestep_start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    neuron_index_counter #(
        .NUM_NEURONS (NUM_NEURONS),
        .ADDR_W      (ADDR_W)
    ) u_idx (
        .clk_i  (CLK),
        .rst_i  (reset),
        .clr_i  (start_ok),
        .inc_i  (state_q == ST_NEXT),
        .idx_o  (idx),
        .last_o (idx_last)
    );

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            operand_q <= '0;
            result_q  <= '0;
            rate_q    <= RATE_DIV1;
            rd_en_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            req_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            rd_en_q <= 1'b0;
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (state_q == ST_IDLE && cfg_we)
                        rate_q <= legal_rate(decay_rate_cfg);
                    if (timestep_start) begin
                        state_q <= ST_READ;
                        rd_en_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_READ: state_q <= ST_WAIT_RD;
                ST_WAIT_RD: begin
                    operand_q <= mem_rd_data;
`ifdef DECAY_SCHED_SKIP_ZERO_EN
                    if ((mem_rd_data[30:0] & FP_MAG_MASK) == '0) begin
                        state_q <= ST_NEXT;
                    end else begin
                        state_q <= ST_ISSUE;
                        req_q   <= 1'b1;
                    end
`else
                    state_q <= ST_ISSUE;
                    req_q   <= 1'b1;
`endif
                end
                ST_ISSUE: begin
                    if (dec_ack) begin
                        result_q <= dec_result;
                        req_q    <= 1'b0;
                        wr_en_q  <= 1'b1;
                        state_q  <= ST_WRITE;
                    end
                end
                ST_WRITE: state_q <= ST_NEXT;
                ST_NEXT: begin
                    if (idx_last) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= ST_READ;
                        rd_en_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    req_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign mem_rd_en   = rd_en_q;
    assign mem_addr    = idx;
    assign mem_wr_en   = wr_en_q;
    assign mem_wr_data = result_q;
    assign dec_req     = req_q;
    assign dec_operand = operand_q;
    // Rate is only presented while a sweep is running so an idle block drives all-zero outputs.
    assign dec_rate    = busy_q ? rate_q : 4'b0000;
    assign busy        = busy_q;
    assign done        = done_q;
    assign overrun     = timestep_start && busy_q;

endmodule

// File: tb/tb_potential_decay_scheduler.sv
// Directed bench for potential_decay_scheduler with a 4-neuron memory and an ack-delay decay model.
module tb_potential_decay_scheduler;

    localparam int NN = 4;
    localparam int AW = 2;

    logic          CLK = 1'b0;
    logic          reset;
    logic          timestep_start;
    logic          cfg_we;
    logic [3:0]    decay_rate_cfg;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_rd_data;
    logic          mem_wr_en;
    logic [31:0]   mem_wr_data;
    logic          dec_req;
    logic [31:0]   dec_operand;
    logic [3:0]    dec_rate;
    logic          dec_ack;
    logic [31:0]   dec_result;
    logic          busy;
    logic          done;
    logic          overrun;

    potential_decay_scheduler #(.NUM_NEURONS(NN), .ADDR_W(AW)) dut (
        .CLK            (CLK),
        .reset          (reset),
        .timestep_start (timestep_start),
        .cfg_we         (cfg_we),
        .decay_rate_cfg (decay_rate_cfg),
        .mem_rd_en      (mem_rd_en),
        .mem_addr       (mem_addr),
        .mem_rd_data    (mem_rd_data),
        .mem_wr_en      (mem_wr_en),
        .mem_wr_data    (mem_wr_data),
        .dec_req        (dec_req),
        .dec_operand    (dec_operand),
        .dec_rate       (dec_rate),
        .dec_ack        (dec_ack),
        .dec_result     (dec_result),
        .busy           (busy),
        .done           (done),
        .overrun        (overrun)
    );

    always #5 CLK = ~CLK;

    // State memory (read-only here; writes are logged) and decay unit that decrements the exponent.
    logic [31:0] mem [0:NN-1];
    always @(posedge CLK) if (mem_rd_en) mem_rd_data <= mem[mem_addr];

    int ack_delay = 0;
    int ack_wait  = 0;
    always @(posedge CLK) begin
        if (!dec_req || dec_ack) ack_wait <= 0;
        else                     ack_wait <= ack_wait + 1;
    end
    assign dec_ack    = dec_req && (ack_wait == ack_delay);
    assign dec_result = dec_operand - 32'h0080_0000;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int            wr_cnt = 0, done_cnt = 0, done_cyc = 0, ovr_cnt = 0;
    int            req_cyc = 0, ack_cnt = 0, busy_cyc = 0, rate_bad = 0, op_bad = 0;
    int            wr_hits [0:NN-1];
    logic [31:0]   wr_log  [0:NN-1];
    logic [AW-1:0] wr_hist [0:255];
    logic          prev_req = 1'b0;
    logic [31:0]   prev_op;
    logic [3:0]    exp_rate = 4'b0001;

    initial for (int i = 0; i < NN; i++) wr_hits[i] = 0;

    always @(negedge CLK) begin
        if (mem_wr_en) begin
            wr_hits[mem_addr] = wr_hits[mem_addr] + 1;
            wr_log[mem_addr]  = mem_wr_data;
            wr_hist[wr_cnt[7:0]] = mem_addr;
            wr_cnt++;
        end
        if (done) begin done_cnt++; done_cyc = cyc; end
        if (overrun) ovr_cnt++;
        if (busy) busy_cyc++;
        if (dec_req) begin
            req_cyc++;
            if (dec_rate !== exp_rate) rate_bad++;
            if (prev_req && dec_operand !== prev_op) op_bad++;
            if (dec_ack) ack_cnt++;
        end
        prev_req = dec_req;
        prev_op  = dec_operand;
    end

    int vec_cnt = 0;
    int err_cnt = 0;
    int start_cyc = 0;

    task automatic tick();
        @(posedge CLK); #1;
    endtask

    task automatic start_pulse();
        timestep_start = 1'b1;
        start_cyc = cyc;
        tick();
        timestep_start = 1'b0;
    endtask

    task automatic wait_done(input int want, input int budget);
        int n = 0;
        while (done_cnt < want && n < budget) begin tick(); n++; end
    endtask

    task automatic load_cfg(input logic [3:0] cfg);
        cfg_we = 1'b1; decay_rate_cfg = cfg;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic fill_mem(input logic [31:0] v);
        for (int i = 0; i < NN; i++) mem[i] = v;
    endtask

    task automatic test_reset();
        reset = 1'b1; timestep_start = 1'b0; cfg_we = 1'b0; decay_rate_cfg = 4'b0000;
        tick(); tick();
        vec_cnt++;
        if ({mem_rd_en, mem_addr, mem_wr_en, mem_wr_data, dec_req, dec_operand, dec_rate, busy, done, overrun} !== '0) begin
            err_cnt++; $display("FAIL reset_outputs: got rd=%b addr=%0d wr=%b req=%b rate=%b busy=%b done=%b ovr=%b expected all 0",
                                mem_rd_en, mem_addr, mem_wr_en, dec_req, dec_rate, busy, done, overrun);
        end
        reset = 1'b0;
        tick(); tick();
        vec_cnt++;
        if ({mem_rd_en, mem_wr_en, dec_req, busy, done, overrun} !== 6'b0) begin
            err_cnt++; $display("FAIL idle_after_reset: got strobes %b expected 000000",
                                {mem_rd_en, mem_wr_en, dec_req, busy, done, overrun});
        end
    endtask

    task automatic test_basic_sweep();
        int w0, d0, b0, r0, q0;
        fill_mem(32'h41DED852);
        ack_delay = 0;
        load_cfg(4'b0010);
        exp_rate = 4'b0010;
        w0 = wr_cnt; d0 = done_cnt; b0 = busy_cyc; r0 = rate_bad; q0 = req_cyc;
        start_pulse();
        wait_done(d0 + 1, 60);
        vec_cnt++;
        if (done_cnt != d0 + 1) begin err_cnt++; $display("FAIL basic_done: got %0d done pulses expected 1", done_cnt - d0); end
        vec_cnt++;
        if (done_cyc - start_cyc != 21) begin err_cnt++; $display("FAIL basic_latency: got %0d expected 21", done_cyc - start_cyc); end
        vec_cnt++;
        if (wr_cnt - w0 != NN) begin err_cnt++; $display("FAIL basic_writes: got %0d expected %0d", wr_cnt - w0, NN); end
        for (int a = 0; a < NN; a++) begin
            vec_cnt++;
            if (wr_log[a] !== 32'h415ED852) begin
                err_cnt++; $display("FAIL basic_data[%0d]: got %h expected 415ed852", a, wr_log[a]);
            end
        end
        vec_cnt++;
        if (busy_cyc - b0 != 20) begin err_cnt++; $display("FAIL basic_busy: got %0d cycles expected 20", busy_cyc - b0); end
        vec_cnt++;
        if (req_cyc - q0 != NN || rate_bad != r0) begin
            err_cnt++; $display("FAIL basic_rate: got %0d req cycles %0d bad rates expected %0d and 0", req_cyc - q0, rate_bad - r0, NN);
        end
    endtask

    task automatic test_ack_delay();
        logic [31:0] pin  [0:NN-1];
        logic [31:0] pout [0:NN-1];
        int h0 [0:NN-1];
        int w0, d0, q0, a0, o0;
        pin[0] = 32'h3F800000; pout[0] = 32'h3F000000;
        pin[1] = 32'h40000000; pout[1] = 32'h3F800000;
        pin[2] = 32'h42C80000; pout[2] = 32'h42480000;
        pin[3] = 32'hC1200000; pout[3] = 32'hC0A00000;
        for (int i = 0; i < NN; i++) begin mem[i] = pin[i]; h0[i] = wr_hits[i]; end
        ack_delay = 3;
        w0 = wr_cnt; d0 = done_cnt; q0 = req_cyc; a0 = ack_cnt; o0 = op_bad;
        start_pulse();
        wait_done(d0 + 1, 100);
        vec_cnt++;
        if (done_cyc - start_cyc != 33 || done_cnt != d0 + 1) begin
            err_cnt++; $display("FAIL delay_latency: got %0d cycles %0d dones expected 33 and 1", done_cyc - start_cyc, done_cnt - d0);
        end
        vec_cnt++;
        if (req_cyc - q0 != 4 * NN) begin err_cnt++; $display("FAIL delay_req_hold: got %0d expected %0d", req_cyc - q0, 4 * NN); end
        vec_cnt++;
        if (ack_cnt - a0 != NN || op_bad != o0) begin
            err_cnt++; $display("FAIL delay_ack_stable: got %0d acks %0d unstable expected %0d and 0", ack_cnt - a0, op_bad - o0, NN);
        end
        vec_cnt++;
        if (wr_cnt - w0 != NN) begin err_cnt++; $display("FAIL delay_writes: got %0d expected %0d", wr_cnt - w0, NN); end
        for (int a = 0; a < NN; a++) begin
            vec_cnt++;
            if (wr_log[a] !== pout[a] || wr_hits[a] - h0[a] != 1) begin
                err_cnt++; $display("FAIL delay_data[%0d]: got %h x%0d expected %h x1", a, wr_log[a], wr_hits[a] - h0[a], pout[a]);
            end
        end
        ack_delay = 0;
    endtask

    task automatic test_overrun_back_to_back();
        int w0, d0, v0, n;
        fill_mem(32'h41DED852);
        ack_delay = 0;
        w0 = wr_cnt; d0 = done_cnt; v0 = ovr_cnt;
        start_pulse();
        repeat (6) tick();
        timestep_start = 1'b1; #1;
        vec_cnt++;
        if (overrun !== 1'b1) begin err_cnt++; $display("FAIL overrun_pulse: got %b expected 1", overrun); end
        tick();
        timestep_start = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 40) begin tick(); n++; end
        vec_cnt++;
        if (done !== 1'b1 || cyc - start_cyc != 21) begin
            err_cnt++; $display("FAIL overrun_latency: got done=%b at %0d expected 1 at 21", done, cyc - start_cyc);
        end
        timestep_start = 1'b1; start_cyc = cyc; #1;
        vec_cnt++;
        if (overrun !== 1'b0) begin err_cnt++; $display("FAIL start_in_done_overrun: got %b expected 0", overrun); end
        tick();
        timestep_start = 1'b0;
        wait_done(d0 + 2, 60);
        vec_cnt++;
        if (ovr_cnt - v0 != 1) begin err_cnt++; $display("FAIL overrun_count: got %0d expected 1", ovr_cnt - v0); end
        vec_cnt++;
        if (wr_cnt - w0 != 2 * NN || done_cnt - d0 != 2) begin
            err_cnt++; $display("FAIL b2b_counts: got %0d writes %0d dones expected %0d and 2", wr_cnt - w0, done_cnt - d0, 2 * NN);
        end
        vec_cnt++;
        if (done_cyc - start_cyc != 21) begin err_cnt++; $display("FAIL b2b_latency: got %0d expected 21", done_cyc - start_cyc); end
    endtask

    task automatic test_cfg_rate();
        logic [3:0] cfgs [0:2];
        logic [3:0] exps [0:2];
        int r0, q0, d0;
        cfgs[0] = 4'b0101; exps[0] = 4'b0001;
        cfgs[1] = 4'b1000; exps[1] = 4'b1000;
        cfgs[2] = 4'b0011; exps[2] = 4'b0011;
        fill_mem(32'h41DED852);
        for (int k = 0; k < 3; k++) begin
            load_cfg(cfgs[k]);
            exp_rate = exps[k];
            r0 = rate_bad; q0 = req_cyc; d0 = done_cnt;
            start_pulse();
            tick(); tick();
            vec_cnt++;
            if (dec_req !== 1'b1 || dec_rate !== exps[k]) begin
                err_cnt++; $display("FAIL cfg_rate_issue[%0d]: got req=%b rate=%b expected 1 %b", k, dec_req, dec_rate, exps[k]);
            end
            load_cfg(4'b1000 ^ exps[k]);
            wait_done(d0 + 1, 60);
            vec_cnt++;
            if (rate_bad != r0 || req_cyc - q0 != NN) begin
                err_cnt++; $display("FAIL cfg_rate_sweep[%0d]: got %0d bad of %0d reqs expected 0 of %0d", k, rate_bad - r0, req_cyc - q0, NN);
            end
        end
    endtask

    task automatic test_reset_in_issue();
        int w0, h2, n;
        fill_mem(32'h41DED852);
        ack_delay = 6;
        w0 = wr_cnt; h2 = wr_hits[2];
        start_pulse();
        n = 0;
        while (!(dec_req === 1'b1 && mem_addr === 2'd2) && n < 60) begin tick(); n++; end
        vec_cnt++;
        if (dec_req !== 1'b1 || mem_addr !== 2'd2) begin
            err_cnt++; $display("FAIL reach_issue_idx2: got req=%b addr=%0d expected 1 2", dec_req, mem_addr);
        end
        reset = 1'b1; #1;
        vec_cnt++;
        if ({mem_rd_en, mem_addr, mem_wr_en, mem_wr_data, dec_req, dec_operand, dec_rate, busy, done, overrun} !== '0) begin
            err_cnt++; $display("FAIL reset_in_issue: got req=%b addr=%0d busy=%b rate=%b expected all 0", dec_req, mem_addr, busy, dec_rate);
        end
        tick();
        reset = 1'b0;
        exp_rate = 4'b0001;
        ack_delay = 0;
        tick();
        vec_cnt++;
        if (wr_cnt - w0 != 2 || wr_hits[2] != h2) begin
            err_cnt++; $display("FAIL reset_no_write: got %0d writes, addr2 x%0d expected 2 and 0", wr_cnt - w0, wr_hits[2] - h2);
        end
        w0 = wr_cnt; n = done_cnt;
        start_pulse();
        wait_done(n + 1, 60);
        vec_cnt++;
        if (wr_cnt - w0 != NN || wr_hist[w0[7:0]] !== 2'd0 || done_cyc - start_cyc != 21) begin
            err_cnt++; $display("FAIL resweep: got %0d writes first addr %0d latency %0d expected %0d 0 21",
                                wr_cnt - w0, wr_hist[w0[7:0]], done_cyc - start_cyc, NN);
        end
    endtask

    task automatic test_skip_zero();
        int w0, d0, q0, h1;
        fill_mem(32'h41DED852);
        mem[1] = 32'h80000000;
        ack_delay = 0;
        w0 = wr_cnt; d0 = done_cnt; q0 = req_cyc; h1 = wr_hits[1];
        start_pulse();
        wait_done(d0 + 1, 60);
`ifdef DECAY_SCHED_SKIP_ZERO_EN
        vec_cnt++;
        if (done_cyc - start_cyc != 19) begin err_cnt++; $display("FAIL skip_latency: got %0d expected 19", done_cyc - start_cyc); end
        vec_cnt++;
        if (wr_cnt - w0 != NN - 1 || wr_hits[1] != h1 || req_cyc - q0 != NN - 1) begin
            err_cnt++; $display("FAIL skip_addr1: got %0d writes %0d addr1 %0d reqs expected %0d 0 %0d",
                                wr_cnt - w0, wr_hits[1] - h1, req_cyc - q0, NN - 1, NN - 1);
        end
`else
        vec_cnt++;
        if (done_cyc - start_cyc != 21) begin err_cnt++; $display("FAIL noskip_latency: got %0d expected 21", done_cyc - start_cyc); end
        vec_cnt++;
        if (wr_cnt - w0 != NN || wr_hits[1] - h1 != 1 || wr_log[1] !== 32'h7F800000) begin
            err_cnt++; $display("FAIL noskip_addr1: got %0d writes addr1 x%0d data %h expected %0d x1 7f800000",
                                wr_cnt - w0, wr_hits[1] - h1, wr_log[1], NN);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_basic_sweep();
        test_ack_delay();
        test_overrun_back_to_back();
        test_cfg_rate();
        test_reset_in_issue();
        test_skip_zero();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
